alu_cmd_sequencer: RTL and testbench

Parallel-to-serial command sequencer for the ALU's serial port. It accepts one operation {A, B, op} over a valid/ready handshake and serializes it onto `sin` with CRC4. It then deserializes the ALU's `sout` response (result frame or error frame) and presents it on a response handshake. The block sits between the test/system master and the ALU, and is the only driver of `sin`.

---
 rtl/alu_pkg.sv | 55 +++++
 rtl/alu_seq_rx.sv | 47 ++++
 rtl/alu_cmd_sequencer.sv | 178 +++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types, packet constants and CRC/parity helpers for the ALU command sequencer.
// The same helpers are available to verification components that import this package.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b100,
        OP_SUB = 3'b101
    } operation_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEND = 3'd1,
        ST_WAIT = 3'd2,
        ST_RECV = 3'd3,
        ST_DONE = 3'd4
    } seq_state_t;

    localparam logic PKT_DATA = 1'b0;
    localparam logic PKT_CTL  = 1'b1;

    // MSB-first serial CRC, polynomial x^4+x+1, init 0
    function automatic logic [3:0] crc4_generate(input logic [67:0] data);
        logic [3:0] crc;
        logic       fb;
        crc = 4'h0;
        for (int i = 67; i >= 0; i--) begin
            fb  = crc[3] ^ data[i];
            crc = {crc[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
        end
        return crc;
    endfunction

    function automatic logic [2:0] crc3_generate(input logic [36:0] data);
        logic [2:0] crc;
        logic       fb;
        crc = 3'h0;
        for (int i = 36; i >= 0; i--) begin
            fb  = crc[2] ^ data[i];
            crc = {crc[1:0], 1'b0} ^ (fb ? 3'b011 : 3'b000);
        end
        return crc;
    endfunction

    // Error ctl bytes carry even parity: bit0 must equal the XOR of bits [7:1]
    function automatic logic parity_bad(input logic [7:0] b);
        return (^b[7:1]) != b[0];
    endfunction

    function automatic logic [10:0] pack_packet(input logic typ, input logic [7:0] b);
        return {1'b0, typ, b, 1'b1};
    endfunction

endpackage

// File: rtl/alu_seq_rx.sv
// Packet deserializer for the ALU response line: hunts a start bit, then samples
// type, 8 payload bits and stop; reports each packet in the cycle its stop bit is sampled.
module alu_seq_rx
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic       sout_i,
    output logic       pkt_valid_o,
    output logic       pkt_type_o,
    output logic [7:0] pkt_byte_o,
    output logic       pkt_stop_err_o
);

    logic       busy_q;
    logic [3:0] cnt_q;
    logic [8:0] shift_q;

    // Start-bit hunt and bit sampling; cnt_q==9 is the stop-bit sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= 1'b0;
            cnt_q   <= 4'd0;
            shift_q <= 9'd0;
        end else if (!en_i) begin
            busy_q <= 1'b0;
            cnt_q  <= 4'd0;
        end else if (!busy_q) begin
            if (!sout_i) begin
                busy_q <= 1'b1;
                cnt_q  <= 4'd0;
            end
        end else if (cnt_q == 4'd9) begin
            busy_q <= 1'b0;
        end else begin
            shift_q <= {shift_q[7:0], sout_i};
            cnt_q   <= cnt_q + 4'd1;
        end
    end

    assign pkt_valid_o    = busy_q && (cnt_q == 4'd9);
    assign pkt_type_o     = shift_q[8];
    assign pkt_byte_o     = shift_q[7:0];
    assign pkt_stop_err_o = ~sout_i;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Serializes one {A, B, op} request onto sin with CRC4 and collects the ALU response.
// Optional response checking (rsp_crc_err) is built when ALU_SEQ_CRC_CHECK_EN is defined.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [2:0]  req_op,
    output logic        sin,
    input  logic        sout,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_c,
    output logic [7:0]  rsp_ctl,
    output logic        rsp_timeout
`ifdef ALU_SEQ_CRC_CHECK_EN
    ,
    output logic        rsp_crc_err
`endif
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    seq_state_t  state_q;
    logic        sin_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_c_q;
    logic [7:0]  rsp_ctl_q;
    logic        rsp_timeout_q;
    logic [97:0] frame_q;
    logic [6:0]  bit_cnt_q;
    logic [TW-1:0] tcnt_q;
    logic [31:0] c_acc_q;
    logic [2:0]  data_idx_q;

    logic [3:0]  crc4_s;
    logic [98:0] frame_s;
    logic        rx_en_s;
    logic        pkt_valid_s;
    logic        pkt_type_s;
    logic [7:0]  pkt_byte_s;
    logic        pkt_stop_err_s;

    assign crc4_s  = crc4_generate({req_b, req_a, 1'b1, req_op});
    assign frame_s = {pack_packet(PKT_DATA, req_b[31:24]), pack_packet(PKT_DATA, req_b[23:16]),
                      pack_packet(PKT_DATA, req_b[15:8]),  pack_packet(PKT_DATA, req_b[7:0]),
                      pack_packet(PKT_DATA, req_a[31:24]), pack_packet(PKT_DATA, req_a[23:16]),
                      pack_packet(PKT_DATA, req_a[15:8]),  pack_packet(PKT_DATA, req_a[7:0]),
                      pack_packet(PKT_CTL, {1'b0, req_op, crc4_s})};
    assign rx_en_s = (state_q == ST_WAIT) || (state_q == ST_RECV);

    alu_seq_rx u_rx (
        .clk            (clk),
        .rst_n          (rst_n),
        .en_i           (rx_en_s),
        .sout_i         (sout),
        .pkt_valid_o    (pkt_valid_s),
        .pkt_type_o     (pkt_type_s),
        .pkt_byte_o     (pkt_byte_s),
        .pkt_stop_err_o (pkt_stop_err_s)
    );

`ifdef ALU_SEQ_CRC_CHECK_EN
    logic rsp_crc_err_q;
    logic crc_bad_s;
    assign crc_bad_s   = pkt_byte_s[7] ? parity_bad(pkt_byte_s)
                       : (crc3_generate({c_acc_q, 1'b0, pkt_byte_s[6:3]}) != pkt_byte_s[2:0]);
    assign rsp_crc_err = rsp_crc_err_q;
`endif

    // Sequencer FSM with serializer, timeout counter and registered response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            sin_q         <= 1'b1;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_c_q       <= 32'd0;
            rsp_ctl_q     <= 8'd0;
            rsp_timeout_q <= 1'b0;
            frame_q       <= 98'd0;
            bit_cnt_q     <= 7'd0;
            tcnt_q        <= '0;
            c_acc_q       <= 32'd0;
            data_idx_q    <= 3'd0;
`ifdef ALU_SEQ_CRC_CHECK_EN
            rsp_crc_err_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        state_q     <= ST_SEND;
                        req_ready_q <= 1'b0;
                        sin_q       <= frame_s[98];
                        frame_q     <= frame_s[97:0];
                        bit_cnt_q   <= 7'd98;
                        c_acc_q     <= 32'd0;
                        data_idx_q  <= 3'd0;
                    end
                end
                ST_SEND: begin
                    if (bit_cnt_q == 7'd0) begin
                        state_q <= ST_WAIT;
                        sin_q   <= 1'b1;
                        tcnt_q  <= '0;
                    end else begin
                        sin_q     <= frame_q[97];
                        frame_q   <= {frame_q[96:0], 1'b1};
                        bit_cnt_q <= bit_cnt_q - 7'd1;
                    end
                end
                ST_WAIT: begin
                    if (!sout) begin
                        state_q <= ST_RECV;
                    end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        state_q       <= ST_DONE;
                        rsp_valid_q   <= 1'b1;
                        rsp_c_q       <= 32'd0;
                        rsp_ctl_q     <= 8'd0;
                        rsp_timeout_q <= 1'b1;
`ifdef ALU_SEQ_CRC_CHECK_EN
                        rsp_crc_err_q <= 1'b0;
`endif
                    end else begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                end
                ST_RECV: begin
                    // Any ctl packet or broken stop bit ends the response
                    if (pkt_valid_s) begin
                        if (pkt_stop_err_s || (pkt_type_s == PKT_CTL)) begin
                            state_q       <= ST_DONE;
                            rsp_valid_q   <= 1'b1;
                            rsp_c_q       <= c_acc_q;
                            rsp_ctl_q     <= pkt_stop_err_s ? 8'hFF : pkt_byte_s;
                            rsp_timeout_q <= 1'b0;
`ifdef ALU_SEQ_CRC_CHECK_EN
                            rsp_crc_err_q <= pkt_stop_err_s | crc_bad_s;
`endif
                        end else if (data_idx_q < 3'd4) begin
                            c_acc_q[{~data_idx_q[1:0], 3'b000} +: 8] <= pkt_byte_s;
                            data_idx_q <= data_idx_q + 3'd1;
                        end
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    sin_q       <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign sin         = sin_q;
    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_c       = rsp_c_q;
    assign rsp_ctl     = rsp_ctl_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Table-driven bench for alu_cmd_sequencer with a behavioural ALU serial responder.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    localparam int TMO = 50;
    localparam logic [1:0] K_RES = 2'd0, K_ERR = 2'd1, K_TMO = 2'd2, K_FRM = 2'd3;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] exp_c;
        logic [3:0]  exp_flags;
        logic [1:0]  kind;
        logic [7:0]  exp_ctl;
    } vec_t;

    logic        clk, rst_n, req_valid, req_ready, sin, sout, rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] req_a, req_b, rsp_c;
    logic [2:0]  req_op;
    logic [7:0]  rsp_ctl;

    int n_cmp = 0;
    int n_err = 0;
    vec_t vecs[7];

    alu_cmd_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .sin(sin), .sout(sout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_c(rsp_c), .rsp_ctl(rsp_ctl),
        .rsp_timeout(rsp_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Polynomial long division, independent of the package LFSR helpers
    function automatic logic [3:0] crc_div4(input logic [67:0] d);
        logic [71:0] r;
        r = {d, 4'h0};
        for (int i = 71; i >= 4; i--)
            if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
        return r[3:0];
    endfunction

    function automatic logic [2:0] crc_div3(input logic [36:0] d);
        logic [39:0] r;
        r = {d, 3'h0};
        for (int i = 39; i >= 3; i--)
            if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
        return r[2:0];
    endfunction

    function automatic logic [10:0] pkt(input logic typ, input logic [7:0] b);
        return {1'b0, typ, b, 1'b1};
    endfunction

    function automatic logic [98:0] exp_frame(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        return {pkt(1'b0, b[31:24]), pkt(1'b0, b[23:16]), pkt(1'b0, b[15:8]), pkt(1'b0, b[7:0]),
                pkt(1'b0, a[31:24]), pkt(1'b0, a[23:16]), pkt(1'b0, a[15:8]), pkt(1'b0, a[7:0]),
                pkt(1'b1, {1'b0, op, crc_div4({b, a, 1'b1, op})})};
    endfunction

    function automatic void alu_model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                                      output logic [31:0] c, output logic [3:0] fl);
        logic [32:0] s;
        logic cy, ov;
        cy = 1'b0; ov = 1'b0; c = 32'd0;
        case (op)
            3'b000: c = a & b;
            3'b001: c = a | b;
            3'b100: begin
                s = {1'b0, a} + {1'b0, b};
                c = s[31:0]; cy = s[32];
                ov = (a[31] == b[31]) && (c[31] != a[31]);
            end
            3'b101: begin
                c = b - a; cy = (b >= a);
                ov = (b[31] != a[31]) && (c[31] != b[31]);
            end
            default: c = 32'd0;
        endcase
        fl = {cy, ov, (c == 32'd0), c[31]};
    endfunction

    task automatic send_pkt(input logic typ, input logic [7:0] b, input logic stop, input bit last);
        logic [10:0] bits;
        bits = {1'b0, typ, b, stop};
        for (int i = 10; i >= 0; i--) begin
            sout = bits[i];
            if (last && i == 0) chk("valid_before_stop", rsp_valid, 1'b0);
            step();
        end
        sout = 1'b1;
    endtask

    // Drive a request and return the cycles until the first start bit appears on sin
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op, output int steps);
        req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
        steps = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            rsp_ready = 1'b0;
            if (sin === 1'b0) begin
                steps = i + 1;
                break;
            end
        end
        req_valid = 1'b0;
        if (steps == 0) chk("accept_bound", 32'd0, 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input bit b2b, input bit hold);
        int steps;
        int stable;
        logic [98:0] fr;
        logic [31:0] mc;
        logic [3:0]  mf;
        logic [7:0]  ectl;
        if (b2b) rsp_ready = 1'b1;
        issue(v.a, v.b, v.op, steps);
        if (b2b) chk("b2b_latency", steps, 2);
        else     chk("accept_latency", steps, 1);
        fr[98] = sin;
        for (int k = 1; k <= 98; k++) begin
            step();
            fr[98 - k] = sin;
        end
        step();
        chk("sin_idle_after_frame", sin, 1'b1);
        chk("frame", fr, exp_frame(v.a, v.b, v.op));
        chk("frame_crc4", fr[4:1], crc4_generate({v.b, v.a, 1'b1, v.op}));
        chk("req_ready_busy", req_ready, 1'b0);
        ectl = v.exp_ctl;
        case (v.kind)
            K_RES: begin
                alu_model(v.a, v.b, v.op, mc, mf);
                repeat (3) step();
                send_pkt(PKT_DATA, mc[31:24], 1'b1, 1'b0);
                send_pkt(PKT_DATA, mc[23:16], 1'b1, 1'b0);
                send_pkt(PKT_DATA, mc[15:8], 1'b1, 1'b0);
                send_pkt(PKT_DATA, mc[7:0], 1'b1, 1'b0);
                send_pkt(PKT_CTL, {1'b0, mf, crc_div3({mc, 1'b0, mf})}, 1'b1, 1'b1);
                ectl = {1'b0, v.exp_flags, crc_div3({v.exp_c, 1'b0, v.exp_flags})};
                chk("rsp_flags", rsp_ctl[6:3], v.exp_flags);
            end
            K_ERR: begin
                step();
                send_pkt(PKT_CTL, v.exp_ctl, 1'b1, 1'b1);
            end
            K_FRM: begin
                step();
                send_pkt(PKT_DATA, 8'h11, 1'b0, 1'b1);
            end
            default: begin
                repeat (TMO - 1) step();
                chk("timeout_early", rsp_valid, 1'b0);
                step();
            end
        endcase
        chk("rsp_valid", rsp_valid, 1'b1);
        if (v.kind != K_FRM) chk("rsp_c", rsp_c, v.exp_c);
        chk("rsp_ctl", rsp_ctl, ectl);
        chk("rsp_timeout", rsp_timeout, (v.kind == K_TMO) ? 1'b1 : 1'b0);
        if (hold) begin
            stable = 0;
            for (int k = 0; k < 20; k++) begin
                step();
                if (rsp_valid === 1'b1 && rsp_c === v.exp_c && rsp_ctl === ectl && req_ready === 1'b0)
                    stable++;
            end
            chk("hold_stable_cycles", stable, 20);
        end else begin
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
            chk("valid_after_handshake", rsp_valid, 1'b0);
            chk("req_ready_after_handshake", req_ready, 1'b1);
        end
    endtask

    initial begin
        int steps;
        vecs[0] = '{32'hF0F0F0F0, 32'hFFFF0000, 3'b000, 32'hF0F00000, 4'b0001, K_RES, 8'h00};
        vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 3'b100, 32'h00000000, 4'b1010, K_RES, 8'h00};
        vecs[2] = '{32'h0F0F0000, 32'h00000F0F, 3'b001, 32'h0F0F0F0F, 4'b0000, K_RES, 8'h00};
        vecs[3] = '{32'h00000001, 32'h00000005, 3'b101, 32'h00000004, 4'b1000, K_RES, 8'h00};
        vecs[4] = '{32'hDEADBEEF, 32'h12345678, 3'b100, 32'h00000000, 4'b0000, K_ERR, 8'hA5};
        vecs[5] = '{32'h00000003, 32'h00000007, 3'b000, 32'h00000000, 4'b0000, K_TMO, 8'h00};
        vecs[6] = '{32'hAAAAAAAA, 32'h55555555, 3'b001, 32'h00000000, 4'b0000, K_FRM, 8'hFF};

        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; sout = 1'b1;
        req_a = 32'd0; req_b = 32'd0; req_op = 3'd0;
        repeat (3) step();
        chk("reset_sin", sin, 1'b1);
        chk("reset_req_ready", req_ready, 1'b1);
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_rsp_c", rsp_c, 32'd0);
        chk("reset_rsp_ctl", rsp_ctl, 8'd0);
        chk("reset_rsp_timeout", rsp_timeout, 1'b0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 7; i++) run_vec(vecs[i], 1'b0, 1'b0);

        // Response held back for 20 cycles, then a request overlapping the handshake
        run_vec(vecs[0], 1'b0, 1'b1);
        run_vec(vecs[1], 1'b1, 1'b0);

        // Reset in the middle of SEND, at bit 40 (B[2]=0 so the line is low there)
        issue(32'h12345678, 32'h00000000, 3'b001, steps);
        repeat (40) step();
        chk("sin_mid_frame", sin, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("sin_async_reset", sin, 1'b1);
        chk("reset_mid_req_ready", req_ready, 1'b1);
        chk("reset_mid_rsp_valid", rsp_valid, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("post_reset_sin", sin, 1'b1);
        chk("post_reset_req_ready", req_ready, 1'b1);
        run_vec(vecs[2], 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
